// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Shares one sequential multiplier between N requesters. It picks one
// requester round-robin and latches that requester's operands. It then pulses
// the multiplier start, follows the multiplier busy flag through the
// operation, and hands the W-bit result back to the requester with a
// one-cycle done strobe. A watchdog sets a sticky error if the multiplier
// never raises busy after a start.
//
// Parameters
//   N         number of requesters (2..8)
//   W         operand / result width, must match the multiplier
//   START_TO  cycles allowed for mult_busy_i to rise after the start pulse
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         asynchronous reset, active low
//   req_i[N]      request per requester, held with stable operands until ack
//   a_i[W*N]      operand A, requester k at bits [W*k +: W]
//   b_i[W*N]      operand B, same packing
//   ack_o[N]      one-hot pulse: operands of requester k accepted
//   done_o[N]     one-hot pulse: y_o valid for requester k
//   y_o[W]        result register, holds its value after done
//   err_o         sticky watchdog fault, cleared only by reset
//   mult_start_o  start pulse to the multiplier
//   mult_a_o/b_o  operands to the multiplier, from internal registers
//   mult_busy_i   busy flag from the multiplier
//   mult_y_i      result from the multiplier
//
// All outputs come straight from registers. No input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int START_TO = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_i,
    input  logic [W*N-1:0] a_i,
    input  logic [W*N-1:0] b_i,
    output logic [N-1:0]   ack_o,
    output logic [N-1:0]   done_o,
    output logic [W-1:0]   y_o,
    output logic           err_o,
    output logic           mult_start_o,
    output logic [W-1:0]   mult_a_o,
    output logic [W-1:0]   mult_b_o,
    input  logic           mult_busy_i,
    input  logic [W-1:0]   mult_y_i
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(START_TO + 1);

    // The watchdog fires on the cycle that would make the count reach START_TO.
    localparam logic [CW-1:0] WD_LAST = CW'(START_TO - 1);
    localparam logic [GW-1:0] LAST_RST = GW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [CW-1:0] r_wd_cnt;
    logic [N-1:0]  r_ack;
    logic [N-1:0]  r_done;
    logic [W-1:0]  r_y;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_start;
    logic          r_err;

    // Unpacked views of the packed operand buses.
    logic [W-1:0]  w_a_lane [N];
    logic [W-1:0]  w_b_lane [N];

    // One-hot decodes of the round-robin winner and the stored grant.
    logic [N-1:0]  w_win_oh;
    logic [N-1:0]  w_grant_oh;

    logic          w_any_req;
    logic [GW-1:0] w_win;

    // The search starts at last+1 and wraps. Scanning from the farthest
    // offset down to the nearest lets the nearest pending request overwrite
    // the others, so the first one in round-robin order wins.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        int            idx;
        pick = last;
        for (int i = N; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                pick = GW'(idx);
            end
        end
        return pick;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign w_a_lane[gi]   = a_i[W*gi +: W];
            assign w_b_lane[gi]   = b_i[W*gi +: W];
            assign w_win_oh[gi]   = (w_win == GW'(gi));
            assign w_grant_oh[gi] = (r_grant == GW'(gi));
        end
    endgenerate

    always_comb begin
        w_any_req = |req_i;
        w_win     = rr_pick(req_i, r_last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_last   <= LAST_RST;
            r_wd_cnt <= '0;
            r_ack    <= '0;
            r_done   <= '0;
            r_y      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // The strobes default low, so each one lasts exactly one cycle.
            r_ack   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_win;
                        r_a     <= w_a_lane[w_win];
                        r_b     <= w_b_lane[w_win];
                        // Ack and start are registered here so they are
                        // high during the START cycle.
                        r_ack   <= w_win_oh;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    r_wd_cnt <= '0;
                    r_state  <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (mult_busy_i) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_wd_cnt == WD_LAST) begin
                        // The multiplier never responded. Release the
                        // requester with the old y_o and flag the fault.
                        // Moving last keeps a dead unit from pinning
                        // priority on one requester.
                        r_err   <= 1'b1;
                        r_done  <= w_grant_oh;
                        r_last  <= r_grant;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CW'(1);
                    end
                end

                S_WAIT_DONE: begin
                    if (!mult_busy_i) begin
                        r_y     <= mult_y_i;
                        r_done  <= w_grant_oh;
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_o        = r_ack;
    assign done_o       = r_done;
    assign y_o          = r_y;
    assign err_o        = r_err;
    assign mult_start_o = r_start;
    assign mult_a_o     = r_a;
    assign mult_b_o     = r_b;

endmodule
